// File: rtl/i2c_event_decoder.sv
// Turns debounced SCL/SDA into 16-bit START/RSTART/BYTE/STOP/TIMEOUT records, one cycle after the bus change.
// Fire-and-forget: a single-cycle valid pulse per record, no backpressure from the FIFO.
module i2c_event_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_SCL,
  input  logic        i_SDA,
  output logic [15:0] o_Event_Data,
  output logic        o_Event_Valid,
  output logic        o_Bus_Busy,
  output logic [3:0]  o_State
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START     = 4'd1,
    ST_BYTE      = 4'd2,
    ST_ACK       = 4'd3,
    ST_ACK_CLOSE = 4'd4
  } state_t;

  localparam logic [3:0] TYPE_START   = 4'd1;
  localparam logic [3:0] TYPE_RSTART  = 4'd2;
  localparam logic [3:0] TYPE_BYTE    = 4'd3;
  localparam logic [3:0] TYPE_STOP    = 4'd4;
  localparam logic [3:0] TYPE_TIMEOUT = 4'd5;
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic                 scl_q, sda_q;
  logic [3:0]           cnt_q, cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                 vld_q, vld_d;
  logic [15:0]          dat_q, dat_d;

  logic scl_rise, scl_fall, scl_edge, start_c, stop_c, abort_c;
  logic [3:0] abort_cnt;

  assign scl_rise  = ~scl_q & i_SCL;
  assign scl_fall  = scl_q & ~i_SCL;
  assign scl_edge  = scl_rise | scl_fall;
  // Requiring SCL high on both samples suppresses START/STOP when SCL moves in the same cycle.
  assign start_c   = sda_q & ~i_SDA & scl_q & i_SCL;
  assign stop_c    = ~sda_q & i_SDA & scl_q & i_SCL;
  assign abort_c   = ((state_q == ST_BYTE) && (cnt_q != 4'd0)) || (state_q == ST_ACK);
  assign abort_cnt = (state_q == ST_ACK) ? 4'd8 : cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      cnt_q   <= 4'd0;
      shift_q <= 8'd0;
      tmo_q   <= '0;
      vld_q   <= 1'b0;
      dat_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      scl_q   <= i_SCL;
      sda_q   <= i_SDA;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      tmo_q   <= tmo_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tmo_d   = tmo_q;
    vld_d   = 1'b0;
    dat_d   = dat_q;
    if (state_q == ST_IDLE) begin
      tmo_d = '0;
      if (start_c) begin
        state_d = ST_START;
        vld_d   = 1'b1;
        dat_d   = {TYPE_START, 12'h000};
      end
    end else if (start_c || stop_c) begin
      state_d = start_c ? ST_START : ST_IDLE;
      cnt_d   = 4'd0;
      tmo_d   = start_c ? tmo_q + TIMEOUT_W'(1) : '0;
      vld_d   = 1'b1;
      dat_d   = {(start_c ? TYPE_RSTART : TYPE_STOP), abort_c, 3'b000, 4'h0,
                 (abort_c ? abort_cnt : 4'h0)};
    end else if (scl_edge) begin
      tmo_d = '0;
      case (state_q)
        ST_START: begin
          if (scl_fall) begin
            state_d = ST_BYTE;
            cnt_d   = 4'd0;
          end
        end
        ST_BYTE: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], i_SDA};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) state_d = ST_ACK;
          end
        end
        ST_ACK: begin
          if (scl_rise) begin
            state_d = ST_ACK_CLOSE;
            vld_d   = 1'b1;
            dat_d   = {TYPE_BYTE, 3'b000, i_SDA, shift_q};
          end
        end
        ST_ACK_CLOSE: begin
          if (scl_fall) begin
            state_d = ST_BYTE;
            cnt_d   = 4'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_q >= TMO_LAST) begin
      state_d = ST_IDLE;
      tmo_d   = '0;
      vld_d   = 1'b1;
      dat_d   = {TYPE_TIMEOUT, 1'b0, 3'b000, 4'h0, cnt_q};
    end else begin
      tmo_d = tmo_q + TIMEOUT_W'(1);
    end
  end

  always_comb begin
    o_State       = state_q;
    o_Bus_Busy    = (state_q != ST_IDLE);
    o_Event_Valid = vld_q;
    o_Event_Data  = dat_q;
  end

endmodule
